// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared counter mode type and load clamping helper for mod_counter.
package mod_counter_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction
endpackage

// File: rtl/mod_counter_prescaler.sv
// mod_counter_prescaler: divides the count enable by ps_div+1.
// Only compiled when MOD_COUNTER_PRESCALER_EN is defined.
`ifdef MOD_COUNTER_PRESCALER_EN
module mod_counter_prescaler #(
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic [PS_WIDTH-1:0] ps_div,
  output logic                tick
);
  logic [PS_WIDTH-1:0] ps;
  assign tick = en & (ps == ps_div);
  // A ratio lowered below the current phase lets ps run to all-ones and wrap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ps <= '0;
    else if (clr) ps <= '0;
    else if (en) ps <= tick ? '0 : ps + 1'b1;
endmodule
`endif

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with wrap/saturate, terminal-count pulse and sticky overflow.
// Optional enable prescaler is compiled in with MOD_COUNTER_PRESCALER_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                up_dn,
  input  cnt_mode_e           mode,
  input  logic [PS_WIDTH-1:0] ps_div,
  input  logic                ovf_clr,
  output logic [WIDTH-1:0]    count,
  output logic                tc,
  output logic                ovf
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic tick, step, hit;
  logic [WIDTH-1:0] nxt;
`ifdef MOD_COUNTER_PRESCALER_EN
  mod_counter_prescaler #(.PS_WIDTH(PS_WIDTH)) u_ps (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr | load),
    .ps_div (ps_div),
    .tick   (tick)
  );
`else
  logic unused_ps_div;
  assign unused_ps_div = ^ps_div;
  assign tick = 1'b1;
`endif
  assign step = en & tick & ~clr & ~load;
  // Boundary is MAX in the up direction and zero in the down direction.
  assign hit = up_dn ? (count == MAX) : (count == '0);
  assign nxt = !hit ? (up_dn ? count + 1'b1 : count - 1'b1) :
               (mode == CNT_SAT) ? count : (up_dn ? '0 : MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= clr ? '0 : load ? WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL))) : step ? nxt : count;
      tc    <= step & hit;
      ovf   <= (step & hit) | (ovf & ~ovf_clr);
    end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: scoreboard bench for mod_counter with MAX_VAL=9 and MAX_VAL=99 instances.
module tb_mod_counter;
  import mod_counter_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0, up_dn = 1'b1, ovf_clr = 1'b0;
  cnt_mode_e mode = CNT_WRAP;
  logic [7:0] load_val = '0;
  logic [3:0] ps_div = '0;
  logic [7:0] count9, count99;
  logic tc9, tc99, ovf9, ovf99;
  typedef struct {logic [7:0] cnt; logic tc; logic ovf;} exp_t;
  typedef struct packed {logic en, clr, load, up, oc; logic [7:0] lv, cnt; logic tc, ovf;} row_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MAX_VAL(9), .PS_WIDTH(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .mode(mode), .ps_div(ps_div), .ovf_clr(ovf_clr),
    .count(count9), .tc(tc9), .ovf(ovf9)
  );
  mod_counter #(.WIDTH(8), .MAX_VAL(99), .PS_WIDTH(4)) dut99 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .mode(mode), .ps_div(ps_div), .ovf_clr(ovf_clr),
    .count(count99), .tc(tc99), .ovf(ovf99)
  );

  task automatic apply(input row_t r);
    {en, clr, load, up_dn, ovf_clr} = {r.en, r.clr, r.load, r.up, r.oc};
    load_val = r.lv;
    sb.push_back('{cnt: r.cnt, tc: r.tc, ovf: r.ovf});
  endtask

  task automatic test_reset;
    sb.push_back('{cnt: 8'd0, tc: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf} || {count99, tc99, ovf99} !== {e.cnt, e.tc, e.ovf}) begin
      errors++;
      $display("FAIL reset: got count=%0d/%0d tc=%b/%b ovf=%b/%b, want count=%0d tc=%b ovf=%b",
               count9, count99, tc9, tc99, ovf9, ovf99, e.cnt, e.tc, e.ovf);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_up_wrap;
    mode = CNT_WRAP;
    for (int i = 0; i < 12; i++) begin
      apply('{en: 1'b1, clr: 1'b0, load: 1'b0, up: 1'b1, oc: 1'b0, lv: 8'd0,
              cnt: 8'((i + 1) % 10), tc: (i == 9), ovf: (i >= 9)});
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL up_wrap[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 i, count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_down_sat;
    row_t r [7] = '{
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0}
    };
    mode = CNT_SAT;
    foreach (r[i]) begin
      apply(r[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL down_sat[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 i, count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_load_clamp;
    row_t r [7] = '{
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd200, 8'd99, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd200, 8'd0,  1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd42,  8'd42, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd98,  8'd98, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd99, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,  1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1}
    };
    mode = CNT_WRAP;
    foreach (r[i]) begin
      apply(r[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count99, tc99, ovf99} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL load_clamp[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 i, count99, tc99, ovf99, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

`ifdef MOD_COUNTER_PRESCALER_EN
  task automatic test_prescaler;
    exp_t q [$];
    mode = CNT_WRAP;
    ps_div = 4'd3;
    apply('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) q.push_back('{cnt: 8'((i + 1) / 4), tc: 1'b0, ovf: 1'b0});
    q.push_back('{cnt: 8'd3, tc: 1'b0, ovf: 1'b0});
    q.push_back('{cnt: 8'd3, tc: 1'b0, ovf: 1'b0});
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        {en, clr, up_dn, ovf_clr} = {1'b1, 1'b0, 1'b1, 1'b0};
        load = (i == 15);
        load_val = 8'd3;
        sb.push_back(i <= 14 ? q[i - 1] : '{cnt: (i == 19) ? 8'd4 : 8'd3, tc: 1'b0, ovf: 1'b0});
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL prescaler[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 i, count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
      end
    end
    ps_div = 4'd0;
  endtask
`endif

  task automatic test_dir_change;
    row_t r [11] = '{
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd4, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd6, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd9, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd8, 1'b0, 1'b1}
    };
    mode = CNT_WRAP;
    foreach (r[i]) begin
      apply(r[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
        errors++;
        $display("FAIL dir_change[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                 i, count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
      end
    end
  endtask

  task automatic test_async_reset;
    apply('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 8'd7, 1'b0, 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
      errors++;
      $display("FAIL async_pre: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
               count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
    end
    load = 1'b0;
    sb.push_back('{cnt: 8'd0, tc: 1'b0, ovf: 1'b0});
    #3 rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    vectors++;
    if ({count9, tc9, ovf9} !== {e.cnt, e.tc, e.ovf}) begin
      errors++;
      $display("FAIL async_reset: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
               count9, tc9, ovf9, e.cnt, e.tc, e.ovf);
    end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_clamp();
`ifdef MOD_COUNTER_PRESCALER_EN
    test_prescaler();
`endif
    test_dir_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter that generalises the basic free-running enable counter. It adds a programmable terminal value, direction control, synchronous clear and load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is the shared counting primitive for timers, event counters and tick generators across the design. An optional prescaler divides the enable rate.

## Interface
- `WIDTH`, 8, counter width in bits (≥2)
- `MAX_VAL`, 2**WIDTH-1, terminal (highest) count value; legal range 1..2**WIDTH-1
- `PS_WIDTH`, 4, prescaler divide-ratio width (used only with prescaler compiled in)

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  clock, all state updates on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `en`  input  1  count enable
- `clr`  input  1  synchronous clear of count, prescaler and tc
- `load`  input  1  synchronous load of `load_val`
- `load_val`  input  WIDTH  value to load
- `up_dn`  input  1  direction, 1 = up, 0 = down
- `mode`  input  1  `cnt_mode_e`: `CNT_WRAP`=0, `CNT_SAT`=1
- `ps_div`  input  PS_WIDTH  prescale ratio minus one; ignored when prescaler not compiled
- `ovf_clr`  input  1  clears sticky `ovf`
- `count`  output  WIDTH  current count
- `tc`  output  1  one-cycle terminal-count pulse
- `ovf`  output  1  sticky boundary-crossing flag

## Operation
- Reset: `count`=0, `tc`=0, `ovf`=0, prescaler=0.
- Per-edge priority: `clr` > `load` > step. Step happens when `en`=1 and `tick`=1. `tick`=1 constantly without the prescaler.
- `clr`: `count`←0, prescaler←0, `tc`←0. `ovf` is unaffected.
- `load`: `count`←min(`load_val`, `MAX_VAL`), prescaler←0, `tc`←0. There is no step that cycle.
- Step, up, `count`<`MAX_VAL`: `count`+1.
- Step, up, `count`==`MAX_VAL`:
  - WRAP mode: `count`←0.
  - SAT mode: `count` holds `MAX_VAL`.
  - Both modes: boundary event.
- Step, down, `count`>0: `count`−1.
- Step, down, `count`==0:
  - WRAP mode: `count`←`MAX_VAL`.
  - SAT mode: `count` holds 0.
  - Both modes: boundary event.
- Boundary event: `tc`←1 for exactly one cycle and `ovf`←1.
  - In SAT mode, repeated steps at the boundary pulse `tc` on every step.
- `ovf_clr` clears `ovf`. If a boundary event occurs on the same edge, set wins.
- Arithmetic is WIDTH-bit unsigned. The boundary compare is against `MAX_VAL`, never against a natural 2**WIDTH rollover.
- `up_dn` and `mode` are sampled every edge. A mid-count direction change takes effect on the next step with no glitch.
- `rst_n` asserted mid-operation forces the reset values immediately, independent of `clk`.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- A step is visible on `count` one cycle after the enabling edge.
- `tc` is high in the same cycle that `count` shows the wrapped or held value.
- Counter latency from `en` to the first change: 1 cycle without the prescaler, `ps_div`+1 enabled cycles with it.
- `clr`/`load` take effect on the next edge (1-cycle latency).

## Configuration
- Macro: `MOD_COUNTER_PRESCALER_EN`.
- Defined:
  - A PS_WIDTH-bit prescaler increments on each `en` cycle.
  - `tick`=1 when prescaler==`ps_div`, and the prescaler then returns to 0.
  - The prescaler holds while `en`=0.
  - `ps_div`=0 gives a step on every enabled cycle.
  - A `ps_div` change while counting applies at the next prescaler compare; if the prescaler is already above the new value, it runs up to all-ones and wraps.
- Undefined: no prescaler logic, `tick` is tied to 1, `ps_div` is unused, and behaviour equals `ps_div`=0.

## Structure
- Package `mod_counter_pkg`: `cnt_mode_e` enum (1-bit) and a helper function for clamping the load value.
- Sub-module `mod_counter_prescaler` (generated under the macro): inputs `clk`, `rst_n`, `en`, `clr` (= `clr`|`load`), `ps_div`; output `tick`.

## Test plan
- Reset, then up/WRAP, `MAX_VAL`=9, `en`=1 for 12 cycles → `count` 0..9,0,1,2; `tc` high only with `count`=0 after 9; `ovf`=1.
- Down/SAT from `load_val`=2 → 2,1,0,0,0; `tc` pulses on each held step at 0; `ovf` sticky until `ovf_clr`, and `ovf` stays 1 when `ovf_clr` coincides with a boundary event.
- `load_val`=200 with `MAX_VAL`=99 → `count`=99. Then `clr`+`load`+`en` on the same edge → `count`=0 (clr wins).
- `up_dn` toggled at `count`=5 → 6 then 5, with no skipped value. `en` low for 3 cycles → `count` holds and `tc`=0.
- With `MOD_COUNTER_PRESCALER_EN`, `ps_div`=3 and `en`=1 for 12 cycles → `count` steps every 4th cycle (0→3). `load` mid-period restarts the 4-cycle spacing.
- `rst_n` pulsed low asynchronously between edges at `count`=7, `ovf`=1 → `count`=0, `tc`=0, `ovf`=0 immediately.
